// File: rtl/pc_redirect_sequencer.sv
// Fetch PC owner: picks PC+4, decode JAL or execute branch/JALR target each cycle,
// shares one external pc+imm adder between requesters, flushes, traps and counts redirects.
module pc_redirect_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_f,
  input  logic             d_jal_valid,
  input  logic [31:0]      d_pc,
  input  logic [31:0]      d_imm,
  input  logic             ex_br_valid,
  input  logic             ex_br_taken,
  input  logic             ex_is_jalr,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_rs1,
  input  logic [31:0]      ex_imm,
  output logic [31:0]      adder_a,
  output logic [31:0]      adder_b,
  input  logic [31:0]      adder_sum,
  output logic [31:0]      pc_f,
  output logic             fetch_valid,
  output logic             flush_d,
  output logic             flush_e,
  output logic             halted,
  output logic [31:0]      trap_pc,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {StBoot, StRun, StTrap} state_e;

  state_e      state_q;
  logic        run;
  logic        ex_req;
  logic        d_req;
  logic        grant;
  logic        misaligned;
  logic [31:0] target;

  always_comb begin
    run     = (state_q == StRun);
    ex_req  = run & ex_br_valid & (ex_br_taken | ex_is_jalr);
    // A JAL alongside a taken EX redirect is on the wrong path and gets flushed.
    d_req   = run & d_jal_valid & ~stall_f & ~ex_req;
    grant   = ex_req | d_req;
    adder_a = '0;
    adder_b = '0;
    if (ex_req) begin
      adder_a = ex_is_jalr ? ex_rs1 : ex_pc;
      adder_b = ex_imm;
    end else if (d_req) begin
      adder_a = d_pc;
      adder_b = d_imm;
    end
    target     = (ex_req & ex_is_jalr) ? (adder_sum & ~32'h1) : adder_sum;
    misaligned = grant & target[1];
    flush_d    = grant;
    flush_e    = ex_req | misaligned;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StBoot;
      pc_f         <= RESET_PC;
      fetch_valid  <= 1'b0;
      halted       <= 1'b0;
      trap_pc      <= '0;
      redirect_cnt <= '0;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_q     <= StRun;
          fetch_valid <= 1'b1;
        end
        StRun: begin
          if (misaligned) begin
            state_q     <= StTrap;
            trap_pc     <= target;
            halted      <= 1'b1;
            fetch_valid <= 1'b0;
          end else if (grant) begin
            pc_f <= target;
            if (redirect_cnt != {CNT_W{1'b1}}) begin
              redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
          end else if (!stall_f) begin
            pc_f <= pc_f + 32'd4;
          end
        end
        StTrap: begin
          state_q <= StTrap;
        end
        default: begin
          state_q <= StBoot;
        end
      endcase
    end
  end

endmodule
